// File: rtl/gcore_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// gcore_pkg : opcodes, accumulator-source codes, FSM states, op classes
// Rev 1.0
// ------------------------------------------------------------------
package gcore_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_JUMP  = 4'b0001;
  localparam logic [3:0] OP_SAVE  = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_LOADI = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_BZ    = 4'b1111;

  localparam logic [1:0] ACC_SEL_MEM = 2'b00;
  localparam logic [1:0] ACC_SEL_IMM = 2'b01;
  localparam logic [1:0] ACC_SEL_ALU = 2'b10;
  localparam logic [1:0] ACC_SEL_SLL = 2'b11;

`ifdef GCORE_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3
  } state_e;
`endif

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_JUMP    = 3'd1,
    CLS_BZ      = 3'd2,
    CLS_MEMRD   = 3'd3,
    CLS_MEMWR   = 3'd4,
    CLS_IMM     = 3'd5,
    CLS_ALU     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_e;

endpackage
`default_nettype wire

// File: rtl/gcore_op_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// gcore_op_decode : combinational opcode-to-class map
// Rev 1.0
// ------------------------------------------------------------------
module gcore_op_decode
  import gcore_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  output op_class_e       op_class
);

  logic hi_set;

  generate
    if (OP_W > 4) begin : g_wide
      assign hi_set = |op[OP_W-1:4];
    end else begin : g_narrow
      assign hi_set = 1'b0;
    end
  endgenerate

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (!hi_set) begin
      case (op[3:0])
        OP_NOP:   op_class = CLS_NOP;
        OP_JUMP:  op_class = CLS_JUMP;
        OP_SAVE:  op_class = CLS_MEMWR;
        OP_LOAD:  op_class = CLS_MEMRD;
        OP_LOADI: op_class = CLS_IMM;
        OP_SLL:   op_class = CLS_IMM;
        OP_BZ:    op_class = CLS_BZ;
        // remaining 1xxx codes (1101 included) go straight to the ALU
        default:  op_class = op[3] ? CLS_ALU : CLS_ILLEGAL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcore_ctrl_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// gcore_ctrl_fsm : multi-cycle FETCH/DECODE/MEM/WB control sequencer
// Define GCORE_ILLEGAL_TRAP_EN to trap undefined opcodes. Rev 1.0
// ------------------------------------------------------------------
module gcore_ctrl_fsm
  import gcore_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    ir_op,
  input  logic               acc_zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               acc_we,
  output logic [1:0]         acc_sel,
  output logic [ALUOP_W-1:0] aluop,
  output logic               retire,
  output logic               trap
);

  state_e    state;
  state_e    state_next;
  op_class_e op_class;

  gcore_op_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .op       (ir_op),
    .op_class (op_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_we     = 1'b0;
    acc_sel    = ACC_SEL_MEM;
    aluop      = '0;
    retire     = 1'b0;
`ifdef GCORE_ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif

    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (op_class)
          CLS_NOP: begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_JUMP: begin
            pc_load    = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_BZ: begin
            pc_load    = acc_zero;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_MEMRD, CLS_MEMWR, CLS_ALU: state_next = ST_MEM;
          CLS_IMM:                       state_next = ST_WB;
          default: begin
`ifdef GCORE_ILLEGAL_TRAP_EN
            state_next = ST_TRAP;
`else
            retire     = 1'b1;
            state_next = ST_FETCH;
`endif
          end
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_class == CLS_MEMWR);
        if (op_class == CLS_ALU) begin
          aluop = ir_op[ALUOP_W-1:0];
        end
        if (mem_ack) begin
          if (op_class == CLS_MEMRD) begin
            acc_we  = 1'b1;
            acc_sel = ACC_SEL_MEM;
          end else if (op_class == CLS_ALU) begin
            acc_we  = 1'b1;
            acc_sel = ACC_SEL_ALU;
          end
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_WB: begin
        acc_we     = 1'b1;
        acc_sel    = (ir_op[3:0] == OP_SLL) ? ACC_SEL_SLL : ACC_SEL_IMM;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end

`ifdef GCORE_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        trap = 1'b1;
      end
`endif

      default: state_next = ST_FETCH;
    endcase

    // Reset forces every output low, which also aborts an outstanding request.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_load = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      acc_we  = 1'b0;
      acc_sel = ACC_SEL_MEM;
      aluop   = '0;
      retire  = 1'b0;
`ifdef GCORE_ILLEGAL_TRAP_EN
      trap    = 1'b0;
`endif
    end
  end

`ifndef GCORE_ILLEGAL_TRAP_EN
  assign trap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcore_ctrl_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_gcore_ctrl_fsm : directed vectors with a retire/snapshot scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_gcore_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ir_op;
  logic       acc_zero;
  logic       mem_ack;
  logic       mem_req, mem_we, ir_load, pc_inc, pc_load, acc_we, retire, trap;
  logic [1:0] acc_sel;
  logic [2:0] aluop;

  gcore_ctrl_fsm #(
    .OP_W    (4),
    .ALUOP_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ir_op    (ir_op),
    .acc_zero (acc_zero),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .ir_load  (ir_load),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .acc_we   (acc_we),
    .acc_sel  (acc_sel),
    .aluop    (aluop),
    .retire   (retire),
    .trap     (trap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {mem_req, mem_we, ir_load, pc_inc, pc_load, acc_we, acc_sel, aluop, retire, trap}
  logic [12:0] outv;
  assign outv = {mem_req, mem_we, ir_load, pc_inc, pc_load, acc_we, acc_sel, aluop, retire, trap};

  localparam logic [12:0] V_ZERO      = 13'b0;
  localparam logic [12:0] V_REQ       = 13'b1_0_0_0_0_0_00_000_0_0;
  localparam logic [12:0] V_FETCH_ACK = 13'b1_0_1_1_0_0_00_000_0_0;
  localparam logic [12:0] V_TRAP      = 13'b0_0_0_0_0_0_00_000_0_1;

  typedef struct {
    int          cyc;
    logic [12:0] v;
    string       name;
  } snap_t;

  typedef struct {
    int         cyc;
    logic [6:0] f;      // {acc_we, acc_sel, aluop, pc_load}
    int         req_n;
    int         we_n;
    int         accwe_n;
    string      name;
  } ret_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       az;
    int         fw;     // fetch wait cycles
    int         mw;     // mem wait cycles
    int         ph;     // 0 none, 1 MEM, 2 WB
    int         lat;    // cycles from fetch start to retire, inclusive
    logic       acc_we;
    logic [1:0] sel;
    logic [2:0] alu;
    logic       pcl;
    int         req_n;
    int         we_n;
  } vec_t;

  snap_t snap_q[$];
  ret_t  ret_q[$];
  vec_t  vecs[$];

  int n_vec = 0;
  int n_err = 0;
  int req_n = 0, we_n = 0, accwe_n = 0;
  logic done = 1'b0;
  logic mon_done = 1'b0;

  // Monitor: snapshot checks by cycle, retire-driven scoreboard pops
  always @(negedge clk) begin
    if (rst) begin
      req_n   = 0;
      we_n    = 0;
      accwe_n = 0;
    end else begin
      req_n   = req_n + int'(mem_req);
      we_n    = we_n + int'(mem_we);
      accwe_n = accwe_n + int'(acc_we);
    end

    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      snap_t s;
      s = snap_q.pop_front();
      n_vec++;
      if (s.cyc != cyc || outv !== s.v) begin
        n_err++;
        $display("FAIL %s @cyc %0d: outputs got %b expected %b", s.name, cyc, outv, s.v);
      end
    end

    if (retire === 1'b1) begin
      if (ret_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_retire @cyc %0d: got retire=1 expected 0", cyc);
      end else begin
        ret_t r;
        r = ret_q.pop_front();
        n_vec++;
        if (r.cyc != cyc) begin
          n_err++;
          $display("FAIL %s latency: retire at cyc %0d expected cyc %0d", r.name, cyc, r.cyc);
        end
        n_vec++;
        if ({acc_we, acc_sel, aluop, pc_load} !== r.f || req_n != r.req_n ||
            we_n != r.we_n || accwe_n != r.accwe_n) begin
          n_err++;
          $display("FAIL %s outputs: got we/sel/alu/pcl=%b req=%0d memwe=%0d accwe=%0d expected %b req=%0d memwe=%0d accwe=%0d",
                   r.name, {acc_we, acc_sel, aluop, pc_load}, req_n, we_n, accwe_n,
                   r.f, r.req_n, r.we_n, r.accwe_n);
        end
      end
      req_n   = 0;
      we_n    = 0;
      accwe_n = 0;
    end

    if (done && !mon_done) begin
      n_vec++;
      if (ret_q.size() != 0 || snap_q.size() != 0) begin
        n_err++;
        $display("FAIL pending_expectations: got %0d retires/%0d snaps left expected 0/0",
                 ret_q.size(), snap_q.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic [12:0] v, input string name);
    snap_q.push_back(snap_t'{cyc, v, name});
  endtask

  // Drives one instruction starting in its first FETCH cycle, acting as the memory.
  task automatic run(input vec_t t);
    int c0;
    c0 = cyc;
    ret_q.push_back(ret_t'{c0 + t.lat - 1, {t.acc_we, t.sel, t.alu, t.pcl},
                           t.req_n, t.we_n, int'(t.acc_we), t.name});
    mem_ack = 1'b0;
    repeat (t.fw) tick();
    mem_ack = 1'b1;
    snap(V_FETCH_ACK, {t.name, "_fetch_ack"});
    tick();
    mem_ack  = 1'b0;
    ir_op    = t.op;
    acc_zero = t.az;
    if (t.ph == 1) begin
      tick();
      repeat (t.mw) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end else if (t.ph == 2) begin
      tick();
      tick();
    end else begin
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    mem_ack  = 1'b0;
    ir_op    = 4'b0000;
    acc_zero = 1'b0;

    //                 name     op       az fw mw ph lat we sel    alu     pcl req mwe
    vecs.push_back(vec_t'{"nop",   4'b0000,0, 1, 0, 0, 3, 0, 2'b00, 3'b000, 0, 2, 0});
    vecs.push_back(vec_t'{"loadi", 4'b0100,0, 0, 0, 2, 3, 1, 2'b01, 3'b000, 0, 1, 0});
    vecs.push_back(vec_t'{"add",   4'b1000,0, 0, 3, 1, 6, 1, 2'b10, 3'b000, 0, 5, 0});
    vecs.push_back(vec_t'{"save",  4'b0010,0, 0, 1, 1, 4, 0, 2'b00, 3'b000, 0, 3, 2});
    vecs.push_back(vec_t'{"bz_t",  4'b1111,1, 0, 0, 0, 2, 0, 2'b00, 3'b000, 1, 1, 0});
    vecs.push_back(vec_t'{"bz_nt", 4'b1111,0, 0, 0, 0, 2, 0, 2'b00, 3'b000, 0, 1, 0});
    vecs.push_back(vec_t'{"load",  4'b0011,0, 2, 0, 1, 5, 1, 2'b00, 3'b000, 0, 4, 0});
    vecs.push_back(vec_t'{"sll",   4'b0101,0, 1, 0, 2, 4, 1, 2'b11, 3'b000, 0, 2, 0});
    vecs.push_back(vec_t'{"sub",   4'b1001,0, 0, 1, 1, 4, 1, 2'b10, 3'b001, 0, 3, 0});
    vecs.push_back(vec_t'{"jump",  4'b0001,0, 0, 0, 0, 2, 0, 2'b00, 3'b000, 1, 1, 0});
    vecs.push_back(vec_t'{"op1101",4'b1101,0, 0, 0, 1, 3, 1, 2'b10, 3'b101, 0, 2, 0});
    vecs.push_back(vec_t'{"slt",   4'b1110,0, 0, 2, 1, 5, 1, 2'b10, 3'b110, 0, 4, 0});
    vecs.push_back(vec_t'{"and",   4'b1010,1, 0, 0, 1, 3, 1, 2'b10, 3'b010, 0, 2, 0});

    // Reset: outputs held low while rst is high
    tick();
    snap(V_ZERO, "reset_hold0");
    tick();
    snap(V_ZERO, "reset_hold1");
    tick();
    rst = 1'b0;
    snap(V_REQ, "post_reset_fetch");

    foreach (vecs[i]) run(vecs[i]);

    // Abort an ADD on its second MEM wait cycle, with a coincident ack
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    ir_op   = 4'b1000;
    tick();
    tick();
    rst     = 1'b1;
    mem_ack = 1'b1;
    snap(V_ZERO, "abort_rst_cycle");
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    snap(V_REQ, "abort_refetch");
    run(vec_t'{"sll_after_abort", 4'b0101, 0, 1, 0, 2, 4, 1, 2'b11, 3'b000, 0, 2, 0});

`ifdef GCORE_ILLEGAL_TRAP_EN
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    ir_op   = 4'b0110;
    snap(V_ZERO, "ill_decode");
    tick();
    repeat (12) begin
      snap(V_TRAP, "trap_hold");
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    run(vec_t'{"ill_0110", 4'b0110, 0, 0, 0, 0, 2, 0, 2'b00, 3'b000, 0, 1, 0});
    run(vec_t'{"ill_0111", 4'b0111, 1, 1, 0, 0, 3, 0, 2'b00, 3'b000, 0, 2, 0});
    snap(V_REQ, "ill_refetch");
    tick();
`endif

    done = 1'b1;
    repeat (3) tick();
    if (!mon_done) begin
      n_vec++;
      n_err++;
      $display("FAIL monitor_finish: got done=0 expected 1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcore_ctrl_fsm.md
# gcore_ctrl_fsm

Multi-cycle control sequencer for the GCore accumulator CPU, replacing the single-cycle opcode decoder. It steps each instruction through FETCH, DECODE, MEM and WB states, handshakes with a wait-stated memory through `mem_req`/`mem_ack`, and drives the PC, instruction-register and accumulator enables. Every output is defined in every state, so the block infers no latches. It sits between the instruction register/PC and the datapath (ALU, accumulator mux, memory port).

## Interface
- `OP_W`, default 4: opcode width, minimum 4. Any set bit above bit 3 makes the opcode undefined.
- `ALUOP_W`, default 3: width of `aluop`. Carries `op[ALUOP_W-1:0]`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ir_op`  in  OP_W  opcode from the instruction register. Valid from DECODE onward.
- `acc_zero`  in  1  accumulator equals zero.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request. Held until `mem_ack`.
- `mem_we`  out  1  the request is a write (SAVE only).
- `ir_load`  out  1  load the instruction register from memory read data.
- `pc_inc`  out  1  PC <= PC+1.
- `pc_load`  out  1  PC <= immediate target.
- `acc_we`  out  1  accumulator write enable.
- `acc_sel`  out  2  accumulator source: 00 MEM, 01 IMM, 10 ALU, 11 SLL.
- `aluop`  out  ALUOP_W  ALU function.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `trap`  out  1  illegal-opcode trap (see Configuration).

## Operation
The opcode map is unchanged:
- NOP 0000, JUMP 0001, SAVE 0010, LOAD 0011, LOADI 0100, SLL 0101.
- ALU group 1xxx excluding 1111: ADD 1000, SUB 1001, AND 1010, OR 1011, XOR 1100, SLT 1110. Opcode 1101 passes straight to the ALU as aluop 101.
- BZ 1111.
- Undefined: 0110, 0111, and any opcode with bits above bit 3 set.

States: FETCH, DECODE, MEM, WB, TRAP.
- **FETCH**: `mem_req`=1, `mem_we`=0. When `mem_ack`=1, assert `ir_load`=1 and `pc_inc`=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- **DECODE** (one cycle):
  - NOP: `retire`, go to FETCH.
  - JUMP: `pc_load`=1, `retire`, go to FETCH.
  - BZ: `pc_load`=`acc_zero`, `retire`, go to FETCH.
  - LOAD, SAVE, ALU group: go to MEM.
  - LOADI, SLL: go to WB.
  - Undefined: go to TRAP if enabled, otherwise behave as NOP.
- **MEM**: `mem_req`=1, `mem_we`=1 for SAVE only. `aluop`=`ir_op[ALUOP_W-1:0]` for the ALU group. When `mem_ack`=1:
  - LOAD: `acc_we`=1 with `acc_sel`=MEM.
  - ALU group: `acc_we`=1 with `acc_sel`=ALU.
  - SAVE: no accumulator write.
  - In all three cases: `retire`, go to FETCH.
- **WB**: `acc_we`=1 with `acc_sel`=IMM (LOADI) or SLL (SLL). `retire`, go to FETCH.
- **TRAP**: `trap`=1, all other outputs 0. Stays in TRAP until `rst`.

Output rules:
- Outputs not listed for a state are 0. `acc_sel` and `aluop` are 0 when unused.
- `mem_ack` is ignored whenever `mem_req`=0.
- `ir_op` may change only on the cycle after `ir_load`.

## Timing
- Reset: while `rst`=1, all outputs are forced to 0. On the next edge the state becomes FETCH.
- Reset mid-operation: an asserted `rst` aborts an outstanding `mem_req` with no write. The memory must drop a pending ack.
- Latency with zero-wait memory (`mem_ack` in the first request cycle):
  - NOP, JUMP, BZ: 2 cycles.
  - LOADI, SLL: 3 cycles.
  - LOAD, SAVE, ALU group: 3 cycles.
- Each memory wait cycle adds 1 cycle in FETCH or MEM.
- Throughput: the next FETCH starts on the edge after `retire`.
- `mem_req` is continuous during a wait: there are no gaps, and it drops on the cycle after `mem_ack`.
- At most one request is outstanding.
- Simultaneous `rst` and `mem_ack`: `rst` wins.

## Configuration
- `GCORE_ILLEGAL_TRAP_EN` defined: an undefined opcode in DECODE moves to TRAP. TRAP holds `trap`=1 and never asserts `retire`.
- Macro not defined: the TRAP state is not compiled, `trap` is tied to 0, and undefined opcodes retire as NOP in 2 cycles.

## Structure
- Shared package `gcore_pkg` holds:
  - opcode constants;
  - `acc_sel` encodings (MEM, IMM, ALU, SLL);
  - state encodings.
- Sub-module `gcore_op_decode` is combinational. It maps `ir_op` to class {NOP, JUMP, BZ, MEMRD, MEMWR, IMM, ALU, ILLEGAL}.
- The FSM and output logic live in `gcore_ctrl_fsm`.

## Test plan
- **Zero-wait LOADI**: fetch ack in cycle 0, `ir_op`=0100. Expect `acc_we`=1 with `acc_sel`=01 in cycle 2, and `retire` in cycle 2.
- **ADD with 3 wait cycles in MEM**: `ir_op`=1000. Expect `mem_req` high for 4 cycles, then `acc_we`=1, `acc_sel`=10, `aluop`=000 in the ack cycle.
- **SAVE**: `ir_op`=0010, ack after 1 wait. Expect `mem_we`=1 for 2 cycles and `acc_we` never asserted.
- **BZ taken and not taken**:
  - `acc_zero`=1: expect `pc_load`=1 in DECODE.
  - `acc_zero`=0: expect `pc_load`=0.
  - Both retire in 2 cycles.
- **Reset mid-MEM wait**: assert `rst` on wait cycle 2. Expect all outputs 0 in the `rst` cycle, and after release FETCH with `mem_req`=1.
- **`ir_op`=0110**:
  - Macro defined: expect `trap`=1 from cycle 2, held for more than 10 cycles with no `retire`.
  - Macro not defined: expect `retire` in cycle 1, then FETCH.
